// File: rtl/sample_frame_packer.sv
// Buffers 2-bit x/y/t samples in a small FIFO and emits one packed
// {p,t,y,x} frame per rate tick towards the moving-average filter.
module sample_frame_packer #(
    parameter int DEPTH  = 4,
    parameter int RATE_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_x,
    input  logic [1:0]             in_y,
    input  logic [1:0]             in_t,
    input  logic [RATE_W-1:0]      rate,
    input  logic                   flush,
    output logic [7:0]             frame_out,
    output logic                   frame_strobe,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             underruns
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [5:0]        mem_q [DEPTH];
    logic [5:0]        mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [RATE_W-1:0] div_q, div_d;
    logic [7:0]        frame_q, frame_d;
    logic              strobe_q, strobe_d;
    logic [7:0]        und_q, und_d;

    logic full;
    logic empty;
    logic push;
    logic tick;
    logic pop;

    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);

    // Ready comes only from registered occupancy, so a pop cannot free a slot
    // for a push in the same cycle.
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;
    assign tick     = (state_q != IDLE) && (div_q >= rate);
    assign pop      = tick && !empty;

    assign frame_out    = frame_q;
    assign frame_strobe = strobe_q;
    assign level        = level_q;
    assign underruns    = und_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_t, in_y, in_x};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) state_d = RUN;
            end
            RUN: begin
                if (flush) state_d = DRAIN;
            end
            DRAIN: begin
                if (tick && empty) state_d = IDLE;
                else if (!flush)   state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d    = '0;
        frame_d  = frame_q;
        strobe_d = 1'b0;
        und_d    = und_q;
        if (state_q != IDLE && !tick) begin
            div_d = div_q + RATE_W'(1);
        end
        unique case (state_q)
            IDLE: begin
                frame_d = 8'h00;
            end
            RUN, DRAIN: begin
                if (pop) begin
                    frame_d  = {2'b11, mem_q[rd_ptr_q]};
                    strobe_d = 1'b1;
                end else if (tick) begin
                    frame_d = 8'h00;
                    if (state_q == RUN && und_q != 8'hFF) begin
                        und_d = und_q + 8'd1;
                    end
                end
            end
            default: frame_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            div_q    <= '0;
            frame_q  <= 8'h00;
            strobe_q <= 1'b0;
            und_q    <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            div_q    <= div_d;
            frame_q  <= frame_d;
            strobe_q <= strobe_d;
            und_q    <= und_d;
        end
    end

    // Sample storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_sample_frame_packer.sv
// Directed bench for sample_frame_packer: vector table for reset/underrun/
// divider behaviour plus hand sequences for full, flush and reset cases.
module tb_sample_frame_packer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_x;
    logic [1:0] in_y;
    logic [1:0] in_t;
    logic [3:0] rate;
    logic       flush;
    logic [7:0] frame_out;
    logic       frame_strobe;
    logic [2:0] level;
    logic [7:0] underruns;

    int tests;
    int fails;
    int idx;
    logic hs;

    sample_frame_packer #(.DEPTH(4), .RATE_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_t         (in_t),
        .rate         (rate),
        .flush        (flush),
        .frame_out    (frame_out),
        .frame_strobe (frame_strobe),
        .level        (level),
        .underruns    (underruns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] x;
        logic [1:0] y;
        logic [1:0] t;
        logic [3:0] rate;
        logic       flush;
        logic       chk;
        logic [7:0] frame;
        logic       strobe;
        logic [2:0] lvl;
        logic       rdy;
        logic [7:0] und;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sample(input int k);
        in_x = 2'(k % 4);
        in_y = 2'((k + 1) % 4);
        in_t = 2'((k + 2) % 4);
    endtask

    task automatic do_reset();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        adv();
        adv();
        rst_n = 1'b0;
    endtask

    function automatic vec_t mk(input logic rst, input logic vld,
                                input logic [3:0] rt, input logic chk,
                                input logic [7:0] fr, input logic sb,
                                input logic [2:0] lv, input logic [7:0] ud);
        vec_t v;
        v.rst    = rst;
        v.vld    = vld;
        v.x      = 2'd1;
        v.y      = 2'd2;
        v.t      = 2'd3;
        v.rate   = rt;
        v.flush  = 1'b0;
        v.chk    = chk;
        v.frame  = fr;
        v.strobe = sb;
        v.lvl    = lv;
        v.rdy    = 1'b1;
        v.und    = ud;
        return v;
    endfunction

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        rate     = 4'd0;
        in_x     = 2'd0;
        in_y     = 2'd0;
        in_t     = 2'd0;

        vecs[0]  = mk(1, 1, 0, 0, 8'h00, 0, 0, 8'd0);
        vecs[1]  = mk(1, 1, 0, 1, 8'h00, 0, 0, 8'd0);
        vecs[2]  = mk(0, 1, 0, 1, 8'h00, 0, 0, 8'd0);
        vecs[3]  = mk(0, 0, 0, 1, 8'h00, 0, 1, 8'd0);
        vecs[4]  = mk(0, 0, 0, 1, 8'h00, 0, 1, 8'd0);
        vecs[5]  = mk(0, 0, 0, 1, 8'hF9, 1, 0, 8'd0);
        vecs[6]  = mk(0, 0, 0, 1, 8'h00, 0, 0, 8'd1);
        vecs[7]  = mk(0, 0, 0, 1, 8'h00, 0, 0, 8'd2);
        vecs[8]  = mk(0, 0, 0, 1, 8'h00, 0, 0, 8'd3);
        vecs[9]  = mk(0, 0, 5, 1, 8'h00, 0, 0, 8'd4);
        vecs[10] = mk(0, 0, 5, 1, 8'h00, 0, 0, 8'd4);
        vecs[11] = mk(0, 0, 1, 1, 8'h00, 0, 0, 8'd4);
        vecs[12] = mk(0, 0, 1, 1, 8'h00, 0, 0, 8'd5);
        vecs[13] = mk(0, 0, 1, 1, 8'h00, 0, 0, 8'd5);
        vecs[14] = mk(0, 0, 1, 1, 8'h00, 0, 0, 8'd6);

        adv();
        for (int i = 0; i < NV; i++) begin
            rst_n    = vecs[i].rst;
            in_valid = vecs[i].vld;
            in_x     = vecs[i].x;
            in_y     = vecs[i].y;
            in_t     = vecs[i].t;
            rate     = vecs[i].rate;
            flush    = vecs[i].flush;
            @(negedge clk);
            if (vecs[i].chk) begin
                check($sformatf("v%0d_frame", i), frame_out, vecs[i].frame);
                check($sformatf("v%0d_strobe", i), frame_strobe, vecs[i].strobe);
                check($sformatf("v%0d_level", i), level, vecs[i].lvl);
                check($sformatf("v%0d_ready", i), in_ready, vecs[i].rdy);
                check($sformatf("v%0d_underruns", i), underruns, vecs[i].und);
            end
            adv();
        end

        // Fill to full at rate=3, keep in_valid high so space is refilled.
        do_reset();
        rate     = 4'd3;
        idx      = 0;
        set_sample(0);
        in_valid = 1'b1;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            case (c)
                4, 5: begin
                    check($sformatf("full_level_c%0d", c), level, 4);
                    check($sformatf("full_ready_c%0d", c), in_ready, 0);
                end
                6: begin
                    check("full_frame0", frame_out, 8'hE4);
                    check("full_strobe0", frame_strobe, 1);
                    check("full_level_after_pop", level, 3);
                    check("full_ready_after_pop", in_ready, 1);
                end
                7: begin
                    check("full_refill_level", level, 4);
                    check("full_strobe_pulse", frame_strobe, 0);
                    check("full_frame_hold", frame_out, 8'hE4);
                end
                9: begin
                    check("tick_full_level", level, 4);
                    check("tick_full_ready", in_ready, 0);
                end
                10: begin
                    check("full_frame1", frame_out, 8'hF9);
                    check("full_strobe1", frame_strobe, 1);
                    check("tick_full_nopush", level, 3);
                end
                11: check("tick_full_push_next", level, 4);
                14: check("full_frame2", frame_out, 8'hCE);
                18: check("full_frame3", frame_out, 8'hD3);
                default: ;
            endcase
            adv();
            if (hs) begin
                idx++;
                set_sample(idx);
            end
        end

        // Flush with three buffered samples at rate=1.
        do_reset();
        rate     = 4'd15;
        idx      = 0;
        set_sample(0);
        in_valid = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            case (c)
                3: begin
                    check("flush_level3", level, 3);
                    check("flush_ready", in_ready, 0);
                end
                4: begin
                    check("flush_frame0", frame_out, 8'hE4);
                    check("flush_strobe0", frame_strobe, 1);
                    check("flush_level2", level, 2);
                    check("flush_ready_drain", in_ready, 0);
                end
                5: check("flush_strobe_gap", frame_strobe, 0);
                6: begin
                    check("flush_frame1", frame_out, 8'hF9);
                    check("flush_strobe1", frame_strobe, 1);
                    check("flush_level1", level, 1);
                end
                8: begin
                    check("flush_frame2", frame_out, 8'hCE);
                    check("flush_strobe2", frame_strobe, 1);
                    check("flush_level0", level, 0);
                end
                10: begin
                    check("flush_idle_frame", frame_out, 8'h00);
                    check("flush_idle_strobe", frame_strobe, 0);
                    check("flush_underruns", underruns, 0);
                end
                13: begin
                    check("idle_frame_hold", frame_out, 8'h00);
                    check("idle_no_underrun", underruns, 0);
                    check("idle_level", level, 0);
                end
                default: ;
            endcase
            adv();
            if (hs) begin
                idx++;
                set_sample(idx);
            end
            if (c == 2) begin
                flush = 1'b1;
                rate  = 4'd1;
            end
            if (c == 9) begin
                flush    = 1'b0;
                in_valid = 1'b0;
                rate     = 4'd0;
            end
        end

        // Reset mid-RUN with two buffered samples.
        do_reset();
        rate     = 4'd15;
        set_sample(0);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 2) check("rst_pre_level", level, 2);
            if (c == 4) check("rst_level_cleared", level, 0);
            if (c >= 5) begin
                check($sformatf("rst_frame_c%0d", c), frame_out, 8'h00);
                check($sformatf("rst_strobe_c%0d", c), frame_strobe, 0);
                check($sformatf("rst_level_c%0d", c), level, 0);
            end
            adv();
            if (c == 0) set_sample(1);
            if (c == 1) in_valid = 1'b0;
            if (c == 2) rst_n = 1'b1;
            if (c == 4) begin
                rst_n = 1'b0;
                rate  = 4'd0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
